// File: rtl/board_reader_pkg.sv
// board_reader_pkg: tile codes, default board size and scan states for board_reader.
package board_reader_pkg;
  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;
  localparam logic [3:0] TILE_HIDDEN  = 4'd9;
  localparam logic [3:0] TILE_FLAG    = 4'd10;
  localparam logic [3:0] TILE_MINE    = 4'd11;
  localparam logic [3:0] TILE_INVALID = 4'd15;
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
endpackage

// File: rtl/board_reader_if.sv
// board_reader_if: valid/ready tile record stream from board_reader to the tile drawer.
interface board_reader_if #(
  parameter int X_W = 3,
  parameter int Y_W = 3
);
  logic           tile_valid;
  logic           tile_ready;
  logic [X_W-1:0] tile_x;
  logic [Y_W-1:0] tile_y;
  logic [3:0]     tile_code;
  modport master (output tile_valid, tile_x, tile_y, tile_code, input tile_ready);
  modport slave  (input tile_valid, tile_x, tile_y, tile_code, output tile_ready);
endinterface

// File: rtl/board_reader_tile_encode.sv
// board_reader_tile_encode: maps one cell's clicked/flagged/mine/count to its tile code.
module board_reader_tile_encode
  import board_reader_pkg::*;
(
  input  logic       clicked,
  input  logic       flagged,
  input  logic       mine,
  input  logic [3:0] count,
  output logic [3:0] code
);
  always_comb
    code = clicked ? (mine ? TILE_MINE : (count > 4'd8 ? 4'd8 : count)) : (flagged ? TILE_FLAG : TILE_HIDDEN);
endmodule

// File: rtl/board_reader.sv
// board_reader: scans every cell once per start, streams tile records, publishes game_won/game_lost.
// Optional BOARD_READER_DIRTY_EN: skip cells whose code matches the last emitted code.
module board_reader
  import board_reader_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   cell_clicked,
  input  logic [ROWS*COLS-1:0]   cell_flagged,
  input  logic [ROWS*COLS-1:0]   cell_mine,
  input  logic [4*ROWS*COLS-1:0] cell_count,
  input  logic [ROWS*COLS-1:0]   cell_won,
  input  logic [ROWS*COLS-1:0]   cell_lost,
  board_reader_if.master         tile,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   game_won,
  output logic                   game_lost
);
  localparam int N   = ROWS * COLS;
  localparam int X_W = $clog2(COLS);
  localparam int Y_W = $clog2(ROWS);
  localparam int I_W = $clog2(N);
  state_t state;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic [I_W-1:0] cur, sel;
  logic [3:0] code;
  logic acc_won, acc_lost, adv, last, load, emit, x_end;
  // The record register doubles as the scan index; sel points at the cell loaded next.
  assign x_end = tile.tile_x == X_W'(COLS - 1);
  assign last  = x_end && tile.tile_y == Y_W'(ROWS - 1);
  assign adv   = state == EMIT && (!tile.tile_valid || tile.tile_ready);
  assign load  = (state == IDLE && start) || (adv && !last);
  assign nx    = (state == IDLE || x_end) ? '0 : tile.tile_x + 1'b1;
  assign ny    = state == IDLE ? '0 : (x_end ? tile.tile_y + 1'b1 : tile.tile_y);
  assign cur   = I_W'(tile.tile_y) * I_W'(COLS) + I_W'(tile.tile_x);
  assign sel   = I_W'(ny) * I_W'(COLS) + I_W'(nx);
  board_reader_tile_encode u_enc (
    .clicked(cell_clicked[sel]),
    .flagged(cell_flagged[sel]),
    .mine   (cell_mine[sel]),
    .count  (cell_count[{sel, 2'b00} +: 4]),
    .code   (code)
  );
`ifdef BOARD_READER_DIRTY_EN
  logic [3:0] store [N];
  assign emit = code != store[sel];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < N; i++) store[i] <= TILE_INVALID;
    else if (state == EMIT && tile.tile_valid && tile.tile_ready)
      store[cur] <= tile.tile_code;
`else
  assign emit = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      tile.tile_valid <= 1'b0;
      tile.tile_x     <= '0;
      tile.tile_y     <= '0;
      tile.tile_code  <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      game_won        <= 1'b0;
      game_lost       <= 1'b0;
      acc_won         <= 1'b1;
      acc_lost        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        tile.tile_x     <= nx;
        tile.tile_y     <= ny;
        tile.tile_code  <= code;
        tile.tile_valid <= emit;
      end
      case (state)
        IDLE: if (start) begin
          state    <= EMIT;
          busy     <= 1'b1;
          acc_won  <= 1'b1;
          acc_lost <= 1'b0;
        end
        EMIT: if (adv) begin
          acc_won  <= acc_won & cell_won[cur];
          acc_lost <= acc_lost | cell_lost[cur];
          if (last) begin
            state           <= DONE;
            tile.tile_valid <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b1;
            game_won        <= acc_won & cell_won[cur];
            game_lost       <= acc_lost | cell_lost[cur];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
